// File: rtl/alu_div_pkg.sv
// Shared definitions for the alu_div block.
// Holds the data width, the number of divide steps per operation and
// the alu_div control state enumeration, plus a magnitude helper used
// when latching signed operands.
package alu_div_pkg;

  localparam int WIDTH = 16;
  localparam int STEPS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Absolute value when is_signed is set and v is negative. 0x8000 maps to
  // 0x8000, which is the correct unsigned magnitude of -32768.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/alu_div_if.sv
// Request/response bundle for alu_div.
// Handshake: the requester raises start with divs/x/y stable; the request
// is accepted on a rising clock edge where busy=0 and ignored otherwise.
// busy stays high until the operation finishes; done is a one-cycle pulse
// marking result/result_hi/C/N/V/Z valid, and those stay held until the
// next accepted request completes. state mirrors the controller state.
//   master : start, divs, x, y out; busy, done, results, flags, state in
//   slave  : the mirror image (used by alu_div)
interface alu_div_if;
  import alu_div_pkg::*;

  logic             start;
  logic             divs;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             C;
  logic             N;
  logic             V;
  logic             Z;
  state_t           state;

  modport master (
    output start, divs, x, y,
    input  busy, done, result, result_hi, C, N, V, Z, state
  );

  modport slave (
    input  start, divs, x, y,
    output busy, done, result, result_hi, C, N, V, Z, state
  );

endinterface

// File: rtl/div_step.sv
// One restoring division step (combinational).
//   rem      : current partial remainder (always < divisor when divisor != 0)
//   dbit     : next dividend bit shifted in
//   divisor  : divisor magnitude
//   rem_next : partial remainder after the trial subtract
//   q_bit    : quotient bit produced by this step
module div_step
  import alu_div_pkg::*;
(
  input  logic [WIDTH-1:0] rem,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // shifted < 2*divisor, so the 17-bit difference lies in (-divisor, divisor)
  // and its top bit is a reliable borrow/sign indicator.
  always_comb begin
    shifted  = {rem, dbit};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/alu_div.sv
// 16-bit signed/unsigned iterative divider.
// An accepted start latches the operands (as magnitudes in signed mode),
// runs 16 restoring steps in CALC, then FIX applies sign correction and the
// divide-by-zero / signed-overflow cases, writes quotient, remainder and
// flags, and pulses done.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : alu_div_if.slave (start/divs/x/y in; busy/done/result/
//                result_hi/C/N/V/Z/state out)
module alu_div
  import alu_div_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  alu_div_if.slave  bus
);

  localparam logic [4:0] LAST_STEP = 5'(STEPS - 1);

  state_t           state, next_state;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] x_raw, dvsr, quot, rem;
  logic             q_neg, r_neg, y_zero, ovf;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             busy, done, n_flag, v_flag, z_flag;
  logic [WIDTH-1:0] result, result_hi;

  div_step u_step (
    .rem      (rem),
    .dbit     (quot[WIDTH-1]),
    .divisor  (dvsr),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = CALC;
      CALC:    if (cnt == LAST_STEP) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
  end

  // Sign correction; divide-by-zero overrides with all-ones and the dividend.
  always_comb begin
    q_fix = q_neg ? -quot : quot;
    r_fix = r_neg ? -rem  : rem;
    if (y_zero) begin
      q_fix = '1;
      r_fix = x_raw;
    end
  end

  // Datapath: operand latch, step counter, iteration, result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      x_raw     <= '0;
      dvsr      <= '0;
      quot      <= '0;
      rem       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      y_zero    <= 1'b0;
      ovf       <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      n_flag    <= 1'b0;
      v_flag    <= 1'b0;
      z_flag    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            x_raw  <= bus.x;
            y_zero <= (bus.y == '0);
            ovf    <= bus.divs && (bus.x == 16'h8000) && (bus.y == 16'hFFFF);
            q_neg  <= bus.divs & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
            r_neg  <= bus.divs & bus.x[WIDTH-1];
            quot   <= magnitude(bus.x, bus.divs);
            dvsr   <= magnitude(bus.y, bus.divs);
            rem    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          // quot doubles as the dividend shift register: its MSB feeds the
          // step while the new quotient bit enters at the bottom.
          rem  <= rem_next;
          quot <= {quot[WIDTH-2:0], q_bit};
          cnt  <= cnt + 5'd1;
        end
        FIX: begin
          done      <= 1'b1;
          result    <= q_fix;
          result_hi <= r_fix;
          n_flag    <= q_fix[WIDTH-1];
          z_flag    <= (q_fix == '0);
          v_flag    <= y_zero | ovf;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.result    = result;
  assign bus.result_hi = result_hi;
  assign bus.C         = 1'b0;
  assign bus.N         = n_flag;
  assign bus.V         = v_flag;
  assign bus.Z         = z_flag;
  assign bus.state     = state;

endmodule

// File: tb/tb_alu_div.sv
// Directed testbench for alu_div. Cycle numbering: the cycle in which start
// is presented is cycle 0; tick() advances to 1 ns after the next rising edge.
module tb_alu_div;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_div_if bus ();

  alu_div dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int passed = 0;
  int total  = 0;
  logic [35:0] last_exp;
  logic [35:0] obs;
  assign obs = {bus.result, bus.result_hi, bus.C, bus.N, bus.V, bus.Z};

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents a request in the current cycle (cycle 0); returns in cycle 1.
  task automatic issue(input logic s, input logic [15:0] a, input logic [15:0] b);
    bus.start = 1'b1;
    bus.divs  = s;
    bus.x     = a;
    bus.y     = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Walks from cycle 'from' up to cycle 18, recording whether busy stayed
  // high, done stayed low and the previous results stayed held throughout.
  task automatic wait_op(input int from, output bit ok);
    ok = 1'b1;
    for (int c = from; c <= 17; c++) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || obs !== last_exp) ok = 1'b0;
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b0; bus.divs = 1'b0; bus.x = '0; bus.y = '0;
    last_exp = '0;
    tick(); tick();
    total++;
    if (obs !== 36'h0) $display("FAIL reset_results: got %h expected %h", obs, 36'h0);
    else passed++;
    total++;
    if ({bus.busy, bus.done} !== 2'b00) $display("FAIL reset_busy_done: got %b expected 00", {bus.busy, bus.done});
    else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_unsigned;
    bit ok;
    logic [35:0] exp = {16'd14, 16'd2, 4'b0000};
    issue(1'b0, 16'd100, 16'd7);
    wait_op(1, ok);
    total++; if (!ok) $display("FAIL unsigned_timing: busy/done/hold wrong in cycles 1-17"); else passed++;
    total++; if ({bus.busy, bus.done} !== 2'b01) $display("FAIL unsigned_done18: got %b expected 01", {bus.busy, bus.done}); else passed++;
    total++; if (obs !== exp) $display("FAIL unsigned_result: got %h expected %h", obs, exp); else passed++;
    last_exp = exp;
    tick();
    total++; if (bus.done !== 1'b0 || obs !== exp) $display("FAIL unsigned_pulse: done=%b res=%h expected 0 %h", bus.done, obs, exp); else passed++;
  endtask

  task automatic test_signed;
    bit ok;
    logic [35:0] exp = {16'hFFFD, 16'hFFFF, 4'b0100};
    issue(1'b1, 16'hFFF9, 16'd2);
    wait_op(1, ok);
    total++; if (!ok) $display("FAIL signed_timing: busy/done/hold wrong in cycles 1-17"); else passed++;
    total++; if ({bus.busy, bus.done} !== 2'b01) $display("FAIL signed_done18: got %b expected 01", {bus.busy, bus.done}); else passed++;
    total++; if (obs !== exp) $display("FAIL signed_result: got %h expected %h", obs, exp); else passed++;
    last_exp = exp;
    tick();
  endtask

  // Divide by zero (both modes) and the 0x8000 / 0xFFFF corner (both modes).
  task automatic test_corners;
    bit ok;
    logic        mode [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] xa   [4] = '{16'h1234, 16'h1234, 16'h8000, 16'h8000};
    logic [15:0] ya   [4] = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
    logic [35:0] ex   [4] = '{{16'hFFFF, 16'h1234, 4'b0110},
                              {16'hFFFF, 16'h1234, 4'b0110},
                              {16'h8000, 16'h0000, 4'b0110},
                              {16'h0000, 16'h8000, 4'b0001}};
    for (int i = 0; i < 4; i++) begin
      issue(mode[i], xa[i], ya[i]);
      wait_op(1, ok);
      total++; if (!ok) $display("FAIL corner%0d_timing: busy/done/hold wrong in cycles 1-17", i); else passed++;
      total++; if ({bus.busy, bus.done} !== 2'b01) $display("FAIL corner%0d_done18: got %b expected 01", i, {bus.busy, bus.done}); else passed++;
      total++; if (obs !== ex[i]) $display("FAIL corner%0d_result: got %h expected %h", i, obs, ex[i]); else passed++;
      last_exp = ex[i];
      tick();
    end
  endtask

  task automatic test_ignore_busy;
    bit ok;
    logic [35:0] exp = {16'd14, 16'd2, 4'b0000};
    issue(1'b0, 16'd100, 16'd7);
    for (int c = 1; c < 5; c++) tick();
    bus.start = 1'b1; bus.divs = 1'b1; bus.x = 16'd50; bus.y = 16'd5;
    tick();
    bus.start = 1'b0;
    wait_op(6, ok);
    total++; if (!ok) $display("FAIL ignore_timing: busy/done/hold wrong in cycles 6-17"); else passed++;
    total++; if ({bus.busy, bus.done} !== 2'b01) $display("FAIL ignore_done18: got %b expected 01", {bus.busy, bus.done}); else passed++;
    total++; if (obs !== exp) $display("FAIL ignore_result: got %h expected %h", obs, exp); else passed++;
    last_exp = exp;
    tick();
  endtask

  task automatic test_reset_abort;
    bit ok;
    bit saw_done = 1'b0;
    logic [35:0] exp = {16'd3, 16'd0, 4'b0000};
    issue(1'b0, 16'd100, 16'd7);
    for (int c = 1; c < 5; c++) tick();
    bus.start = 1'b1; bus.divs = 1'b0; bus.x = 16'd50; bus.y = 16'd5;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    total++; if (bus.busy !== 1'b1) $display("FAIL abort_busy8: got %b expected 1", bus.busy); else passed++;
    reset = 1'b1;
    #1;
    total++;
    if ({obs, bus.busy, bus.done} !== 38'h0) $display("FAIL abort_reset_outputs: got %h expected 0", {obs, bus.busy, bus.done});
    else passed++;
    last_exp = '0;
    tick(); tick();
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1'b1;
      tick();
    end
    total++; if (saw_done) $display("FAIL abort_no_done: done or busy seen after reset, expected idle"); else passed++;
    issue(1'b0, 16'd9, 16'd3);
    wait_op(1, ok);
    total++; if (!ok) $display("FAIL abort_new_timing: busy/done/hold wrong in cycles 1-17"); else passed++;
    total++; if ({bus.busy, bus.done} !== 2'b01) $display("FAIL abort_new_done18: got %b expected 01", {bus.busy, bus.done}); else passed++;
    total++; if (obs !== exp) $display("FAIL abort_new_result: got %h expected %h", obs, exp); else passed++;
    last_exp = exp;
    tick();
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [35:0] exp1 = {16'd6, 16'd2, 4'b0000};
    logic [35:0] exp2 = {16'hFFFD, 16'hFFFF, 4'b0100};
    issue(1'b0, 16'd20, 16'd3);
    wait_op(1, ok);
    total++; if ({bus.busy, bus.done} !== 2'b01) $display("FAIL b2b_first_done: got %b expected 01", {bus.busy, bus.done}); else passed++;
    total++; if (obs !== exp1) $display("FAIL b2b_first_result: got %h expected %h", obs, exp1); else passed++;
    last_exp = exp1;
    // new request presented in the done cycle
    issue(1'b1, 16'hFFF9, 16'd2);
    wait_op(1, ok);
    total++; if (!ok) $display("FAIL b2b_second_timing: busy/done/hold wrong in cycles 1-17"); else passed++;
    total++; if ({bus.busy, bus.done} !== 2'b01) $display("FAIL b2b_second_done: got %b expected 01", {bus.busy, bus.done}); else passed++;
    total++; if (obs !== exp2) $display("FAIL b2b_second_result: got %h expected %h", obs, exp2); else passed++;
    last_exp = exp2;
    tick();
    total++; if (bus.done !== 1'b0) $display("FAIL b2b_pulse: got %b expected 0", bus.done); else passed++;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_corners();
    test_ignore_busy();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_div.md
ALU_DIV -- requirements
Module: alu_div

Interface
REQ-001 The module SHALL have no parameters; the data width is fixed at 16 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a division; sampled only when busy=0.
REQ-005 divs  input  1  1 = signed (two's complement) divide, 0 = unsigned; sampled with start.
REQ-006 x  input  16  dividend; sampled with start.
REQ-007 y  input  16  divisor; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse; results valid.
REQ-010 result  output  16  quotient; held until the next accepted start.
REQ-011 result_hi  output  16  remainder; held until the next accepted start.
REQ-012 C, N, V, Z  output  1 each  status flags, held with the results.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, FIX; reset enters IDLE.
REQ-014 In IDLE, start=1 at a rising edge SHALL latch x, y and divs, clear the 5-bit step counter and enter CALC.
REQ-015 In signed mode, operands SHALL be converted to magnitudes at latch time, with quotient sign = x[15]^y[15] and remainder sign = x[15] recorded.
REQ-016 CALC SHALL perform one restoring shift/subtract step per cycle for exactly 16 cycles, then enter FIX.
REQ-017 FIX SHALL apply sign correction, write result, result_hi and flags, pulse done, and return to IDLE.
REQ-018 Timing: with start sampled in cycle 0, busy SHALL be high in cycles 1-17, and done high only in cycle 18; busy SHALL be 0 in cycle 18, and a start in cycle 18 SHALL be accepted.
REQ-019 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-020 Signed quotients SHALL truncate toward zero; the remainder SHALL take the dividend's sign, so that x = q*y + r.
REQ-021 Divide by zero (y=0, either mode) SHALL give result=0xFFFF, result_hi=x and V=1, with the normal latency.
REQ-022 Signed overflow (x=0x8000, y=0xFFFF, divs=1) SHALL give result=0x8000, result_hi=0 and V=1.
REQ-023 Flags SHALL be Z=(result==0), N=result[15] and C=0; V=1 only per REQ-021 and REQ-022.
REQ-024 result, result_hi and the flags SHALL change only in the FIX cycle.

Reset
REQ-025 Asserting reset SHALL immediately force state=IDLE, and busy, done, result, result_hi, C, N, V and Z all to 0.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after reset release SHALL be accepted normally.

Structure
REQ-027 The shared uv-risc package SHALL hold the data-width constant (16), the step-count constant (16) and the alu_div state enumeration.
REQ-028 One combinational sub-module div_step SHALL implement a single shift/compare/subtract step: partial remainder and dividend bit in; next partial remainder and quotient bit out.
REQ-029 The remainder of the block (operand latch, FSM, counter, sign fix, flags) SHALL stay in alu_div.

Verification
REQ-030 Unsigned x=100, y=7, start in cycle 0 -> done in cycle 18 only; result=14, result_hi=2, Z=N=V=0.
REQ-031 Signed x=0xFFF9 (-7), y=2 -> result=0xFFFD (-3), result_hi=0xFFFF (-1), N=1, V=0.
REQ-032 x=0x1234, y=0 (unsigned and signed) -> result=0xFFFF, result_hi=0x1234, V=1, done in cycle 18.
REQ-033 Signed 0x8000/0xFFFF -> result=0x8000, result_hi=0, V=1, N=1; the same operands unsigned -> result=0, result_hi=0x8000, Z=1, V=0.
REQ-034 Start 100/7, pulse start with 50/5 in cycle 5, then assert reset in cycle 8 -> the second start has no effect, all outputs are 0 immediately on reset, there is no done pulse, and a new start 9/3 after release gives result=3, result_hi=0, with done 18 cycles later.
REQ-035 Back-to-back: start asserted again in the done cycle -> accepted, with the second done pulse 18 cycles later and the first results held until that FIX cycle.
